// File: rtl/alu_result_checker_if.sv
// Stimulus/response bundle between a vector source, the unit under test and the
// result checker. Vector side drives i_*; the checker reports on o_*.
interface alu_result_checker_if #(
  parameter int M     = 4,
  parameter int CNT_W = 8
);
  logic             i_start;
  logic             i_stop;
  logic             i_valid;
  logic [M-1:0]     i_exp_result;
  logic [3:0]       i_exp_status;
  logic [3:0]       i_status_mask;
  logic [M-1:0]     i_dut_result;
  logic [3:0]       i_dut_status;
  logic             o_busy;
  logic             o_done;
  logic             o_pass;
  logic             o_mismatch;
  logic [CNT_W-1:0] o_checked_cnt;
  logic [CNT_W-1:0] o_error_cnt;
  logic [CNT_W-1:0] o_first_err_idx;

  modport master (
    output i_start, i_stop, i_valid, i_exp_result, i_exp_status, i_status_mask,
    output i_dut_result, i_dut_status,
    input  o_busy, o_done, o_pass, o_mismatch, o_checked_cnt, o_error_cnt, o_first_err_idx
  );

  modport slave (
    input  i_start, i_stop, i_valid, i_exp_result, i_exp_status, i_status_mask,
    input  i_dut_result, i_dut_status,
    output o_busy, o_done, o_pass, o_mismatch, o_checked_cnt, o_error_cnt, o_first_err_idx
  );
endinterface

// File: rtl/alu_result_checker.sv
// Response checker: delays expected result/status by the unit latency, compares
// against the unit outputs and keeps saturating pass/fail statistics per run.
module alu_result_checker #(
  parameter int M       = 4,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 8
) (
  input  logic i_clk,
  input  logic i_reset,
  alu_result_checker_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [M-1:0] res;
    logic [3:0]   st;
    logic [3:0]   msk;
  } ent_t;

  localparam int DW = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_nx;
  logic [DW-1:0]    drain_cnt;
  logic             flush, capture, stop_ld, busy, done;

  logic [LATENCY:1] vld_pipe;
  ent_t [LATENCY:1] dat_pipe;
  ent_t             cap_ent;
  ent_t             last;
  logic             cmp, mis;

  logic [CNT_W-1:0] checked_cnt, error_cnt, first_idx;
  logic             mis_q;

  // ---------------- FSM ----------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.i_start) state_nx = RUN;
      RUN:     if (bus.i_stop)  state_nx = DRAIN;
      DRAIN:   if (drain_cnt == DW'(1)) state_nx = DONE;
      DONE:    if (bus.i_start) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    flush   = 1'b0;
    capture = 1'b0;
    stop_ld = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE:  flush = bus.i_start;
      RUN:   begin capture = 1'b1; stop_ld = bus.i_stop; busy = 1'b1; end
      DRAIN: busy  = 1'b1;
      DONE:  begin flush = bus.i_start; done = 1'b1; end
      default: ;
    endcase
  end

  // Loaded with LATENCY so DONE lands on the edge of the last in-flight compare.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)              drain_cnt <= '0;
    else if (stop_ld)         drain_cnt <= DW'(LATENCY);
    else if (state == DRAIN)  drain_cnt <= drain_cnt - DW'(1);
  end

  // ---------------- expectation delay line ----------------
  always_comb begin
    cap_ent.res = bus.i_exp_result;
    cap_ent.st  = bus.i_exp_status;
    cap_ent.msk = bus.i_status_mask;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else if (flush) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= capture && bus.i_valid;
      dat_pipe[1] <= cap_ent;
      for (int i = 2; i <= LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign last = dat_pipe[LATENCY];
  assign cmp  = vld_pipe[LATENCY];
  assign mis  = (bus.i_dut_result != last.res) ||
                (|((bus.i_dut_status ^ last.st) & last.msk));

  // ---------------- statistics ----------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      checked_cnt <= '0;
      error_cnt   <= '0;
      first_idx   <= '0;
      mis_q       <= 1'b0;
    end else begin
      mis_q <= cmp && mis;
      if (flush) begin
        checked_cnt <= '0;
        error_cnt   <= '0;
        first_idx   <= '0;
      end else if (cmp) begin
        if (checked_cnt != CNT_MAX) checked_cnt <= checked_cnt + 1'b1;
        if (mis) begin
          if (error_cnt != CNT_MAX) error_cnt <= error_cnt + 1'b1;
          // error_cnt never returns to zero within a run, so this marks the first miss
          if (error_cnt == '0) first_idx <= checked_cnt;
        end
      end
    end
  end

  assign bus.o_busy          = busy;
  assign bus.o_done          = done;
  assign bus.o_pass          = done && (error_cnt == '0) && (checked_cnt != '0);
  assign bus.o_mismatch      = mis_q;
  assign bus.o_checked_cnt   = checked_cnt;
  assign bus.o_error_cnt     = error_cnt;
  assign bus.o_first_err_idx = first_idx;

endmodule

// File: tb/tb_alu_result_checker.sv
// Bench for alu_result_checker: two instances (LATENCY=1/CNT_W=8 and LATENCY=3/CNT_W=3)
// checked every cycle against a timestamped expectation-queue model.
module tb_alu_result_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  logic       st [2];
  logic       sp [2];
  logic       vl [2];
  logic [3:0] er [2];
  logic [3:0] es [2];
  logic [3:0] mk [2];
  logic [3:0] rr [2];
  logic [3:0] rs [2];
  logic [3:0] dr [2];
  logic [3:0] ds [2];

  alu_result_checker_if #(.M(4), .CNT_W(8)) ifa ();
  alu_result_checker_if #(.M(4), .CNT_W(3)) ifb ();

  assign ifa.i_start = st[0];  assign ifb.i_start = st[1];
  assign ifa.i_stop  = sp[0];  assign ifb.i_stop  = sp[1];
  assign ifa.i_valid = vl[0];  assign ifb.i_valid = vl[1];
  assign ifa.i_exp_result  = er[0];  assign ifb.i_exp_result  = er[1];
  assign ifa.i_exp_status  = es[0];  assign ifb.i_exp_status  = es[1];
  assign ifa.i_status_mask = mk[0];  assign ifb.i_status_mask = mk[1];
  assign ifa.i_dut_result  = dr[0];  assign ifb.i_dut_result  = dr[1];
  assign ifa.i_dut_status  = ds[0];  assign ifb.i_dut_status  = ds[1];

  alu_result_checker #(.M(4), .LATENCY(1), .CNT_W(8)) dut_a (
    .i_clk(clk), .i_reset(rst), .bus(ifa.slave));
  alu_result_checker #(.M(4), .LATENCY(3), .CNT_W(3)) dut_b (
    .i_clk(clk), .i_reset(rst), .bus(ifb.slave));

  int d_busy [2], d_done [2], d_pass [2], d_mis [2];
  int d_chk [2], d_err [2], d_first [2];
  assign d_busy[0]  = int'(ifa.o_busy);          assign d_busy[1]  = int'(ifb.o_busy);
  assign d_done[0]  = int'(ifa.o_done);          assign d_done[1]  = int'(ifb.o_done);
  assign d_pass[0]  = int'(ifa.o_pass);          assign d_pass[1]  = int'(ifb.o_pass);
  assign d_mis[0]   = int'(ifa.o_mismatch);      assign d_mis[1]   = int'(ifb.o_mismatch);
  assign d_chk[0]   = int'(ifa.o_checked_cnt);   assign d_chk[1]   = int'(ifb.o_checked_cnt);
  assign d_err[0]   = int'(ifa.o_error_cnt);     assign d_err[1]   = int'(ifb.o_error_cnt);
  assign d_first[0] = int'(ifa.o_first_err_idx); assign d_first[1] = int'(ifb.o_first_err_idx);

  function automatic int lat(int k);  return (k == 0) ? 1 : 3;   endfunction
  function automatic int cmax(int k); return (k == 0) ? 255 : 7; endfunction

  task automatic check(string name, int act, int exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase: 0 idle, 1 running, 2 draining, 3 finished. Each captured vector is a
  // queue entry stamped with the edge number at which it must be judged.
  typedef struct {
    int k; int due;
    logic [3:0] er, es, mk, rr, rs;
  } ent_t;

  ent_t q[$];
  int   ph [2], done_at [2], m_chk [2], m_err [2], m_first [2];
  int   m_mis [2];
  int   n = 0;

  task automatic model_clear();
    q.delete();
    for (int k = 0; k < 2; k++) begin
      ph[k] = 0; done_at[k] = 0; m_chk[k] = 0; m_err[k] = 0; m_first[k] = 0; m_mis[k] = 0;
    end
  endtask

  task automatic model_edge(int k);
    int mis = 0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].k == k && q[i].due == n) begin
        mis = ((dr[k] != q[i].er) || (((ds[k] ^ q[i].es) & q[i].mk) != 4'd0)) ? 1 : 0;
        if (mis == 1 && m_err[k] == 0) m_first[k] = m_chk[k];
        if (m_chk[k] < cmax(k)) m_chk[k]++;
        if (mis == 1 && m_err[k] < cmax(k)) m_err[k]++;
        q.delete(i);
      end
    end
    m_mis[k] = mis;
    case (ph[k])
      0, 3: if (st[k]) begin m_chk[k] = 0; m_err[k] = 0; m_first[k] = 0; ph[k] = 1; end
      1: begin
        if (vl[k]) q.push_back('{k, n + lat(k), er[k], es[k], mk[k], rr[k], rs[k]});
        if (sp[k]) begin ph[k] = 2; done_at[k] = n + lat(k); end
      end
      2: if (n == done_at[k]) ph[k] = 3;
      default: ;
    endcase
  endtask

  // Plays the unit: presents each vector's planned response on the edge it is judged.
  task automatic drive_unit(int k);
    dr[k] = 4'($urandom);
    ds[k] = 4'($urandom);
    foreach (q[i]) if (q[i].k == k && q[i].due == n + 1) begin
      dr[k] = q[i].rr;
      ds[k] = q[i].rs;
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_clear();
      else begin
        n++;
        for (int k = 0; k < 2; k++) model_edge(k);
        #1;
        for (int k = 0; k < 2; k++) drive_unit(k);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int mis_seen = 0;
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (!rst) begin
        if (d_mis[0] == 1) mis_seen++;
        for (int k = 0; k < 2; k++) begin
          check($sformatf("busy[%0d]", k),    d_busy[k],  (ph[k] == 1 || ph[k] == 2) ? 1 : 0);
          check($sformatf("done[%0d]", k),    d_done[k],  (ph[k] == 3) ? 1 : 0);
          check($sformatf("pass[%0d]", k),    d_pass[k],
                (ph[k] == 3 && m_err[k] == 0 && m_chk[k] != 0) ? 1 : 0);
          check($sformatf("mismatch[%0d]", k), d_mis[k],  m_mis[k]);
          check($sformatf("checked[%0d]", k), d_chk[k],   m_chk[k]);
          check($sformatf("errors[%0d]", k),  d_err[k],   m_err[k]);
          check($sformatf("first[%0d]", k),   d_first[k], m_first[k]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(int k, logic s, logic p, logic v,
                     logic [3:0] e_r, logic [3:0] e_s, logic [3:0] m,
                     logic [3:0] r_r, logic [3:0] r_s);
    @(negedge clk);
    for (int j = 0; j < 2; j++) begin st[j] = 1'b0; sp[j] = 1'b0; vl[j] = 1'b0; end
    st[k] = s; sp[k] = p; vl[k] = v;
    er[k] = e_r; es[k] = e_s; mk[k] = m; rr[k] = r_r; rs[k] = r_s;
  endtask

  task automatic idle(int k, int c);
    repeat (c) cyc(k, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic all_zero(int k, string tag);
    check({tag, "_busy"},  d_busy[k],  0);
    check({tag, "_done"},  d_done[k],  0);
    check({tag, "_pass"},  d_pass[k],  0);
    check({tag, "_mis"},   d_mis[k],   0);
    check({tag, "_chk"},   d_chk[k],   0);
    check({tag, "_err"},   d_err[k],   0);
    check({tag, "_first"}, d_first[k], 0);
  endtask

  logic [3:0] vec [5];
  logic [3:0] e, s, m;
  int mb;

  initial begin
    for (int j = 0; j < 2; j++) begin
      st[j] = 0; sp[j] = 0; vl[j] = 0; er[j] = 0; es[j] = 0; mk[j] = 0;
      rr[j] = 0; rs[j] = 0; dr[j] = 0; ds[j] = 0;
    end
    vec[0] = 4'b1000; vec[1] = 4'b1100; vec[2] = 4'b1111; vec[3] = 4'b1001; vec[4] = 4'b1111;
    #1;
    all_zero(0, "rst_a");
    all_zero(1, "rst_b");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // valid pulses while idle must not be counted
    cyc(0, 0, 0, 1, 4'd3, 4'd0, 4'hF, 4'd5, 4'd0);
    cyc(0, 0, 1, 1, 4'd3, 4'd0, 4'hF, 4'd5, 4'd0);
    idle(0, 2);
    check("idle_checked", d_chk[0], 0);
    check("idle_busy", d_busy[0], 0);

    // clean run
    cyc(0, 1, 0, 0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, vec[i], 4'd0, 4'd0, vec[i], 4'($urandom));
    cyc(0, 0, 1, 0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    after_edge();
    check("clean_drain_busy", d_busy[0], 1);
    check("clean_drain_done", d_done[0], 0);
    idle(0, 1);
    after_edge();
    check("clean_done", d_done[0], 1);
    check("clean_checked", d_chk[0], 5);
    check("clean_errors", d_err[0], 0);
    check("clean_pass", d_pass[0], 1);

    // one corrupted result
    mb = mis_seen;
    cyc(0, 1, 0, 0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    for (int i = 0; i < 5; i++)
      cyc(0, 0, 0, 1, vec[i], 4'd0, 4'd0, (i == 1) ? 4'b0111 : vec[i], 4'd0);
    cyc(0, 0, 1, 0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    idle(0, 3);
    check("mis_pulses", mis_seen - mb, 1);
    check("mis_errors", d_err[0], 1);
    check("mis_first_idx", d_first[0], 1);
    check("mis_pass", d_pass[0], 0);

    // status masking
    cyc(0, 1, 0, 0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    cyc(0, 0, 0, 1, 4'b0101, 4'b0010, 4'b0010, 4'b0101, 4'b0011);
    cyc(0, 0, 1, 0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    idle(0, 3);
    check("mask_hide_errors", d_err[0], 0);
    check("mask_hide_pass", d_pass[0], 1);
    cyc(0, 1, 0, 0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    cyc(0, 0, 0, 1, 4'b0101, 4'b0010, 4'b0001, 4'b0101, 4'b0011);
    cyc(0, 0, 1, 0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    idle(0, 3);
    check("mask_show_errors", d_err[0], 1);
    check("mask_show_pass", d_pass[0], 0);

    // saturation and drain timing on the 3-deep instance
    cyc(1, 1, 0, 0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    for (int i = 0; i < 10; i++) begin
      e = 4'($urandom);
      cyc(1, 0, 0, 1, e, 4'd0, 4'd0, ~e, 4'd0);
    end
    cyc(1, 0, 1, 0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      after_edge();
      check("sat_drain_busy", d_busy[1], 1);
      check("sat_drain_done", d_done[1], 0);
      idle(1, 1);
    end
    after_edge();
    check("sat_done", d_done[1], 1);
    check("sat_checked", d_chk[1], 7);
    check("sat_errors", d_err[1], 7);
    check("sat_first", d_first[1], 0);

    // reset while vectors are in flight
    cyc(1, 1, 0, 0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    cyc(1, 0, 0, 1, 4'd2, 4'd0, 4'd0, 4'd9, 4'd0);
    cyc(1, 0, 0, 1, 4'd4, 4'd0, 4'd0, 4'd8, 4'd0);
    idle(1, 1);
    check("pre_rst_busy", d_busy[1], 1);
    #3;
    rst = 1'b1;
    #1;
    all_zero(1, "mid_rst_b");
    all_zero(0, "mid_rst_a");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc(1, 1, 0, 0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    cyc(1, 0, 0, 1, 4'd6, 4'd1, 4'hF, 4'd6, 4'd1);
    cyc(1, 0, 1, 0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    idle(1, 6);
    check("post_rst_checked", d_chk[1], 1);
    check("post_rst_errors", d_err[1], 0);
    check("post_rst_pass", d_pass[1], 1);

    // randomized runs; the per-cycle compare judges every edge
    for (int r = 0; r < 24; r++) begin
      int k;
      int len;
      k = r % 2;
      len = $urandom_range(3, 24);
      cyc(k, 1, 0, 0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
      for (int i = 0; i < len; i++) begin
        e = 4'($urandom); s = 4'($urandom); m = 4'($urandom);
        cyc(k, $urandom_range(0, 7) == 0, 1'b0, $urandom_range(0, 3) != 0, e, s, m,
            ($urandom_range(0, 3) == 0) ? 4'($urandom) : e,
            ($urandom_range(0, 3) == 0) ? 4'($urandom) : s);
      end
      e = 4'($urandom); s = 4'($urandom); m = 4'($urandom);
      cyc(k, $urandom_range(0, 1) == 1, 1'b1, $urandom_range(0, 1) == 1, e, s, m,
          ($urandom_range(0, 1) == 1) ? 4'($urandom) : e, s);
      for (int i = 0; i < lat(k) + 2; i++) begin
        e = 4'($urandom);
        cyc(k, 1'b0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, e, 4'd0, 4'd0, e, 4'd0);
      end
      check("rand_run_done", d_done[k], 1);
    end

    idle(0, 3);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/alu_result_checker.md
Name: alu_result_checker

Overview:
Synthesizable response checker for the synchronous arithmetic unit. It is the receiving end of the stimulus interface. For each applied operand/op vector, a vector source supplies the expected result and expected status. The checker delays those expectations by the unit's pipeline latency, compares them against the unit's o_result/o_status, and accumulates pass/fail statistics. Run-control FSM: idle, run, drain, done.

Parameters:
M, 4, operand/result width (matches unit's M)
LATENCY, 1, edges from vector capture to unit output valid; legal range >= 1
CNT_W, 8, width of checked/error counters and first-error index

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous, active-high reset
i_start  in  1  begin a check run (pulse)
i_stop  in  1  end a run; drains in-flight vectors (pulse)
i_valid  in  1  a vector is applied to the unit this cycle
i_exp_result  in  M  expected o_result for this vector
i_exp_status  in  4  expected o_status for this vector
i_status_mask  in  4  1 = compare that status bit; captured with the vector
i_dut_result  in  M  unit o_result
i_dut_status  in  4  unit o_status
o_busy  out  1  state is RUN or DRAIN
o_done  out  1  state is DONE
o_pass  out  1  o_done && error_cnt==0 && checked_cnt!=0
o_mismatch  out  1  one-cycle pulse, registered at the comparison edge that failed
o_checked_cnt  out  CNT_W  vectors compared
o_error_cnt  out  CNT_W  vectors mismatched
o_first_err_idx  out  CNT_W  0-based index of first mismatching vector; 0 if none

Behaviour:
- Reset: asynchronous, active-high. All outputs 0, state IDLE, delay line valid bits cleared. Applies immediately, including mid-run.
- Delay line: LATENCY-stage shift register of {valid, exp_result, exp_status, mask}.
  - Stage 0 loads at every edge.
  - Its valid bit = i_valid && state==RUN. In IDLE, DRAIN and DONE, bubbles are pushed.
- Compare: at an edge where the last stage is valid, the entry is checked.
  - mismatch = (i_dut_result != exp_result) || (((i_dut_status ^ exp_status) & mask) != 0).
  - A vector captured at edge k is therefore compared at edge k+LATENCY.
- Counters: checked_cnt increments on every compare; error_cnt increments on every mismatch. Both saturate at 2^CNT_W-1, with no wrap.
- First error: o_first_err_idx latches the pre-increment checked_cnt on the first mismatch of a run only.
  - A saturated checked_cnt is latched as-is.
- o_mismatch: high for exactly the cycle after a failing compare edge; otherwise 0.
- FSM:
  - IDLE: i_start -> RUN; counters, index and delay line cleared on that edge. i_stop ignored.
  - RUN: i_stop -> DRAIN and load a drain counter with LATENCY. i_start ignored. A vector with i_valid on the same edge as i_stop is still captured.
  - DRAIN: no captures; compares continue; counter decrements each edge. At 1 -> DONE.
  - DONE: statistics held. i_start -> RUN with counters cleared.
  - i_start and i_stop together: start wins in IDLE/DONE; stop wins in RUN; both ignored in DRAIN.
- Drain timing: the last captured vector's compare and the DONE transition occur on the same edge. Status outputs derive from registered state with no combinational path from i_dut_*.

Test Plan:
- Reset: assert i_reset mid-cycle -> all outputs 0 without a clock edge; FSM IDLE; i_valid pulses in IDLE leave counters 0.
- Clean run (M=4, LATENCY=1):
  - Stimulus: start, then 5 vectors with i_exp_result = 4'b1000, 4'b1100, 4'b1111, 4'b1001, 4'b1111; mask 4'b0000; model echoes each expectation one edge later; then stop.
  - Required: o_busy for the drain edge, then o_done=1, o_checked_cnt=5, o_error_cnt=0, o_pass=1.
- Result mismatch: as above, but the model returns 4'b0111 for vector 2 (expected 4'b1100) -> o_mismatch high exactly one cycle; final o_error_cnt=1, o_first_err_idx=1, o_pass=0.
- Status masking: exp_status 4'b0010 vs dut 4'b0011.
  - Mask 4'b0010 -> no error.
  - Mask 4'b0001 -> error_cnt increments; result bits equal in both cases.
- Saturation and latency (CNT_W=3, LATENCY=3): 10 all-mismatching vectors then stop -> DONE exactly 3 edges after stop; checked_cnt=7, error_cnt=7, first_err_idx=0.
- Reset mid-run: start, 2 vectors, assert i_reset before the compares -> counters 0, IDLE; after release, start plus 1 matching vector plus stop -> checked_cnt=1, pass=1, with no stale compare from the flushed vectors.
